// File: rtl/rv32_decode_stage.sv
// RV32I decode stage: splits the fetched word into register indices, immediate,
// one-hot instruction class and one-hot ALU op, registered one cycle behind fetch.
module rv32_decode_stage #(
  parameter int ILLEGAL_CHECK = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  input  logic        i_ce,
  input  logic        i_stall,
  input  logic        i_flush,
  output logic        o_stall,
  output logic        o_ce,
  output logic [31:0] o_pc,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  output logic [4:0]  o_rd_addr,
  output logic [2:0]  o_funct3,
  output logic [31:0] o_imm,
  output logic [10:0] o_opcode,
  output logic [13:0] o_alu,
  output logic        o_illegal
);

  localparam int OP_RTYPE  = 10;
  localparam int OP_ITYPE  = 9;
  localparam int OP_LOAD   = 8;
  localparam int OP_STORE  = 7;
  localparam int OP_BRANCH = 6;
  localparam int OP_JAL    = 5;
  localparam int OP_JALR   = 4;
  localparam int OP_LUI    = 3;
  localparam int OP_AUIPC  = 2;
  localparam int OP_SYSTEM = 1;
  localparam int OP_FENCE  = 0;

  localparam int ALU_ADD  = 13;
  localparam int ALU_SUB  = 12;
  localparam int ALU_SLT  = 11;
  localparam int ALU_SLTU = 10;
  localparam int ALU_XOR  = 9;
  localparam int ALU_OR   = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_SLL  = 6;
  localparam int ALU_SRL  = 5;
  localparam int ALU_SRA  = 4;
  localparam int ALU_EQ   = 3;
  localparam int ALU_NEQ  = 2;
  localparam int ALU_GE   = 1;
  localparam int ALU_GEU  = 0;

  // Immediate selected by instruction class; classes without an immediate give 0.
  function automatic logic signed [31:0] imm_gen(input logic [31:0] inst,
                                                 input logic [10:0] cls);
    logic signed [31:0] imm;
    imm = '0;
    if (cls[OP_ITYPE] || cls[OP_LOAD] || cls[OP_JALR])
      imm = {{20{inst[31]}}, inst[31:20]};
    else if (cls[OP_STORE])
      imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    else if (cls[OP_BRANCH])
      imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    else if (cls[OP_LUI] || cls[OP_AUIPC])
      imm = {inst[31:12], 12'b0};
    else if (cls[OP_JAL])
      imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    return imm;
  endfunction

  function automatic logic [13:0] alu_gen(input logic [31:0] inst,
                                          input logic [10:0] cls);
    logic [13:0] alu;
    alu = '0;
    if (cls[OP_RTYPE] || cls[OP_ITYPE]) begin
      case (inst[14:12])
        3'b000:  alu[(cls[OP_RTYPE] && inst[30]) ? ALU_SUB : ALU_ADD] = 1'b1;
        3'b010:  alu[ALU_SLT]  = 1'b1;
        3'b011:  alu[ALU_SLTU] = 1'b1;
        3'b100:  alu[ALU_XOR]  = 1'b1;
        3'b110:  alu[ALU_OR]   = 1'b1;
        3'b111:  alu[ALU_AND]  = 1'b1;
        3'b001:  alu[ALU_SLL]  = 1'b1;
        default: alu[inst[30] ? ALU_SRA : ALU_SRL] = 1'b1;
      endcase
    end else if (cls[OP_BRANCH]) begin
      case (inst[14:12])
        3'b000:  alu[ALU_EQ]   = 1'b1;
        3'b001:  alu[ALU_NEQ]  = 1'b1;
        3'b100:  alu[ALU_SLT]  = 1'b1;
        3'b101:  alu[ALU_GE]   = 1'b1;
        3'b110:  alu[ALU_SLTU] = 1'b1;
        3'b111:  alu[ALU_GEU]  = 1'b1;
        default: alu[ALU_ADD]  = 1'b1;
      endcase
    end else begin
      alu[ALU_ADD] = 1'b1;
    end
    return alu;
  endfunction

  logic [10:0]        cls_p0;
  logic [13:0]        alu_p0;
  logic signed [31:0] imm_p0;
  logic               unmapped_p0;
  logic               illegal_p0;

  always_comb begin
    cls_p0      = '0;
    unmapped_p0 = 1'b0;
    case (i_inst[6:2])
      5'b01100: cls_p0[OP_RTYPE]  = 1'b1;
      5'b00100: cls_p0[OP_ITYPE]  = 1'b1;
      5'b00000: cls_p0[OP_LOAD]   = 1'b1;
      5'b01000: cls_p0[OP_STORE]  = 1'b1;
      5'b11000: cls_p0[OP_BRANCH] = 1'b1;
      5'b11011: cls_p0[OP_JAL]    = 1'b1;
      5'b11001: cls_p0[OP_JALR]   = 1'b1;
      5'b01101: cls_p0[OP_LUI]    = 1'b1;
      5'b00101: cls_p0[OP_AUIPC]  = 1'b1;
      5'b11100: cls_p0[OP_SYSTEM] = 1'b1;
      5'b00011: cls_p0[OP_FENCE]  = 1'b1;
      default:  unmapped_p0       = 1'b1;
    endcase
    imm_p0     = imm_gen(i_inst, cls_p0);
    alu_p0     = alu_gen(i_inst, cls_p0);
    illegal_p0 = (ILLEGAL_CHECK != 0) &&
                 ((i_inst[1:0] != 2'b11) || unmapped_p0 ||
                  (cls_p0[OP_BRANCH] && (i_inst[14:13] == 2'b01)));
    if (illegal_p0) begin
      cls_p0 = '0;
      alu_p0 = '0;
    end
  end

  logic               stall_q;
  logic               stall_bit;
  logic               load_p0;
  logic               vld_p1;
  logic [31:0]        pc_p1;
  logic [4:0]         rs1_p1;
  logic [4:0]         rs2_p1;
  logic [4:0]         rd_p1;
  logic [2:0]         funct3_p1;
  logic signed [31:0] imm_p1;
  logic [10:0]        cls_p1;
  logic [13:0]        alu_p1;
  logic               illegal_p1;

  // The extra registered stall cycle makes the stage emit one bubble after a stall releases.
  assign stall_bit = i_stall | stall_q;
  assign load_p0   = i_ce & ~stall_bit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_q <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      stall_q <= i_stall;
      if (!stall_bit)
        vld_p1 <= i_flush ? 1'b0 : i_ce;
      else if (!i_stall)
        vld_p1 <= 1'b0;
    end
  end

  // ---- p0 -> p1 stage boundary ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_p1      <= '0;
      rs1_p1     <= '0;
      rs2_p1     <= '0;
      rd_p1      <= '0;
      funct3_p1  <= '0;
      imm_p1     <= '0;
      cls_p1     <= '0;
      alu_p1     <= '0;
      illegal_p1 <= 1'b0;
    end else if (load_p0) begin
      pc_p1      <= i_pc;
      rs1_p1     <= i_inst[19:15];
      rs2_p1     <= i_inst[24:20];
      rd_p1      <= i_inst[11:7];
      funct3_p1  <= i_inst[14:12];
      imm_p1     <= imm_p0;
      cls_p1     <= cls_p0;
      alu_p1     <= alu_p0;
      illegal_p1 <= illegal_p0;
    end
  end

  assign o_stall    = stall_bit;
  assign o_ce       = vld_p1;
  assign o_pc       = pc_p1;
  assign o_rs1_addr = rs1_p1;
  assign o_rs2_addr = rs2_p1;
  assign o_rd_addr  = rd_p1;
  assign o_funct3   = funct3_p1;
  assign o_imm      = imm_p1;
  assign o_opcode   = cls_p1;
  assign o_alu      = alu_p1;
  assign o_illegal  = illegal_p1;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Directed bench for rv32_decode_stage: hand-decoded instruction words and
// stall/flush/reset sequences checked against constant expectations.
module tb_rv32_decode_stage;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_inst;
  logic [31:0] i_pc;
  logic        i_ce;
  logic        i_stall;
  logic        i_flush;
  logic        o_stall;
  logic        o_ce;
  logic [31:0] o_pc;
  logic [4:0]  o_rs1_addr;
  logic [4:0]  o_rs2_addr;
  logic [4:0]  o_rd_addr;
  logic [2:0]  o_funct3;
  logic [31:0] o_imm;
  logic [10:0] o_opcode;
  logic [13:0] o_alu;
  logic        o_illegal;

  int total = 0;
  int bad   = 0;

  localparam logic [10:0] C_RTYPE  = 11'h400;
  localparam logic [10:0] C_ITYPE  = 11'h200;
  localparam logic [10:0] C_STORE  = 11'h080;
  localparam logic [10:0] C_BRANCH = 11'h040;
  localparam logic [10:0] C_JAL    = 11'h020;
  localparam logic [10:0] C_LUI    = 11'h008;
  localparam logic [13:0] A_ADD    = 14'h2000;
  localparam logic [13:0] A_SUB    = 14'h1000;
  localparam logic [13:0] A_SLT    = 14'h0800;
  localparam logic [13:0] A_SRA    = 14'h0010;
  localparam logic [13:0] A_EQ     = 14'h0008;

  rv32_decode_stage #(.ILLEGAL_CHECK(1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_inst(i_inst), .i_pc(i_pc), .i_ce(i_ce),
    .i_stall(i_stall), .i_flush(i_flush), .o_stall(o_stall), .o_ce(o_ce),
    .o_pc(o_pc), .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
    .o_rd_addr(o_rd_addr), .o_funct3(o_funct3), .o_imm(o_imm),
    .o_opcode(o_opcode), .o_alu(o_alu), .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_inst = 32'h0; i_pc = 32'h0; i_ce = 1'b0;
    i_stall = 1'b0; i_flush = 1'b0;
    step(); step();
    total++; if (o_ce !== 1'b0) begin bad++; $display("FAIL reset_ce got=%0b want=0", o_ce); end
    total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", o_stall); end
    total++; if ({o_pc, o_imm, o_opcode, o_alu, o_illegal} !== 90'h0) begin bad++; $display("FAIL reset_payload pc=%h imm=%h op=%h alu=%h ill=%0b want all 0", o_pc, o_imm, o_opcode, o_alu, o_illegal); end
    i_rst = 1'b0;
    step();
  endtask

  task automatic test_addi();
    i_inst = 32'h00500093; i_pc = 32'h100; i_ce = 1'b1;
    step();
    total++; if (o_ce !== 1'b1) begin bad++; $display("FAIL addi_ce got=%0b want=1", o_ce); end
    total++; if ({o_rd_addr, o_rs1_addr} !== {5'd1, 5'd0}) begin bad++; $display("FAIL addi_regs rd=%0d rs1=%0d want 1,0", o_rd_addr, o_rs1_addr); end
    total++; if (o_imm !== 32'd5) begin bad++; $display("FAIL addi_imm got=%h want=5", o_imm); end
    total++; if ({o_opcode, o_alu, o_illegal} !== {C_ITYPE, A_ADD, 1'b0}) begin bad++; $display("FAIL addi_class op=%h alu=%h ill=%0b want %h %h 0", o_opcode, o_alu, o_illegal, C_ITYPE, A_ADD); end
    total++; if (o_pc !== 32'h100) begin bad++; $display("FAIL addi_pc got=%h want=100", o_pc); end
  endtask

  task automatic test_back_to_back();
    i_inst = 32'h402081B3; i_pc = 32'h104; i_ce = 1'b1;
    step();
    total++; if ({o_opcode, o_alu} !== {C_RTYPE, A_SUB}) begin bad++; $display("FAIL sub_class op=%h alu=%h want %h %h", o_opcode, o_alu, C_RTYPE, A_SUB); end
    total++; if ({o_rd_addr, o_rs1_addr, o_rs2_addr} !== {5'd3, 5'd1, 5'd2}) begin bad++; $display("FAIL sub_regs rd=%0d rs1=%0d rs2=%0d want 3,1,2", o_rd_addr, o_rs1_addr, o_rs2_addr); end
    total++; if (o_imm !== 32'h0) begin bad++; $display("FAIL sub_imm got=%h want=0", o_imm); end
    i_inst = 32'hFE000EE3; i_pc = 32'h108;
    step();
    total++; if ({o_opcode, o_alu, o_imm} !== {C_BRANCH, A_EQ, 32'hFFFFFFFC}) begin bad++; $display("FAIL beq op=%h alu=%h imm=%h want %h %h fffffffc", o_opcode, o_alu, o_imm, C_BRANCH, A_EQ); end
    i_inst = 32'h123452B7; i_pc = 32'h10C;
    step();
    total++; if ({o_opcode, o_alu, o_rd_addr, o_imm} !== {C_LUI, A_ADD, 5'd5, 32'h12345000}) begin bad++; $display("FAIL lui op=%h alu=%h rd=%0d imm=%h want %h %h 5 12345000", o_opcode, o_alu, o_rd_addr, o_imm, C_LUI, A_ADD); end
    i_inst = 32'h008000EF;
    step();
    total++; if ({o_opcode, o_rd_addr, o_imm} !== {C_JAL, 5'd1, 32'd8}) begin bad++; $display("FAIL jal op=%h rd=%0d imm=%h want %h 1 8", o_opcode, o_rd_addr, o_imm, C_JAL); end
    i_inst = 32'h40335293;
    step();
    total++; if ({o_opcode, o_alu, o_rs1_addr, o_imm} !== {C_ITYPE, A_SRA, 5'd6, 32'h403}) begin bad++; $display("FAIL srai op=%h alu=%h rs1=%0d imm=%h want %h %h 6 403", o_opcode, o_alu, o_rs1_addr, o_imm, C_ITYPE, A_SRA); end
    i_inst = 32'h0020A423;
    step();
    total++; if ({o_opcode, o_alu, o_funct3, o_imm} !== {C_STORE, A_ADD, 3'b010, 32'd8}) begin bad++; $display("FAIL sw op=%h alu=%h f3=%0d imm=%h want %h %h 2 8", o_opcode, o_alu, o_funct3, o_imm, C_STORE, A_ADD); end
    i_inst = 32'h0020C463;
    step();
    total++; if ({o_opcode, o_alu} !== {C_BRANCH, A_SLT}) begin bad++; $display("FAIL blt op=%h alu=%h want %h %h", o_opcode, o_alu, C_BRANCH, A_SLT); end
  endtask

  task automatic test_stall();
    i_inst = 32'h00500093; i_ce = 1'b1;
    step();
    i_stall = 1'b1; i_inst = 32'h402081B3;
    #1;
    total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL stall_comb got=%0b want=1", o_stall); end
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if ({o_ce, o_rd_addr, o_opcode} !== {1'b1, 5'd1, C_ITYPE}) begin bad++; $display("FAIL stall_hold%0d ce=%0b rd=%0d op=%h want 1 1 %h", k, o_ce, o_rd_addr, o_opcode, C_ITYPE); end
    end
    i_stall = 1'b0;
    #1;
    total++; if (o_stall !== 1'b1) begin bad++; $display("FAIL stall_q_tail got=%0b want=1", o_stall); end
    step();
    total++; if ({o_ce, o_rd_addr} !== {1'b0, 5'd1}) begin bad++; $display("FAIL stall_bubble ce=%0b rd=%0d want 0 1", o_ce, o_rd_addr); end
    total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL stall_release got=%0b want=0", o_stall); end
    step();
    total++; if ({o_ce, o_rd_addr, o_opcode} !== {1'b1, 5'd3, C_RTYPE}) begin bad++; $display("FAIL stall_resume ce=%0b rd=%0d op=%h want 1 3 %h", o_ce, o_rd_addr, o_opcode, C_RTYPE); end
  endtask

  task automatic test_flush();
    i_flush = 1'b1; i_ce = 1'b1; i_inst = 32'h00500093;
    step();
    total++; if (o_ce !== 1'b0) begin bad++; $display("FAIL flush_ce got=%0b want=0", o_ce); end
    i_flush = 1'b0;
    step();
    total++; if (o_ce !== 1'b1) begin bad++; $display("FAIL flush_recover got=%0b want=1", o_ce); end
    i_stall = 1'b1; i_flush = 1'b1;
    step();
    total++; if (o_ce !== 1'b1) begin bad++; $display("FAIL flush_in_stall got=%0b want=1", o_ce); end
    i_stall = 1'b0; i_flush = 1'b0;
    step(); step();
    i_ce = 1'b0;
    step();
    total++; if (o_ce !== 1'b0) begin bad++; $display("FAIL ce_low got=%0b want=0", o_ce); end
  endtask

  task automatic test_illegal();
    i_ce = 1'b1; i_inst = 32'h00000000;
    step();
    total++; if ({o_ce, o_illegal, o_opcode, o_alu} !== {1'b1, 1'b1, 11'h0, 14'h0}) begin bad++; $display("FAIL illegal_zero ce=%0b ill=%0b op=%h alu=%h want 1 1 0 0", o_ce, o_illegal, o_opcode, o_alu); end
    i_inst = 32'h00002063;
    step();
    total++; if ({o_illegal, o_opcode, o_alu} !== {1'b1, 11'h0, 14'h0}) begin bad++; $display("FAIL illegal_brf3 ill=%0b op=%h alu=%h want 1 0 0", o_illegal, o_opcode, o_alu); end
    i_inst = 32'h0000007F;
    step();
    total++; if ({o_illegal, o_opcode} !== {1'b1, 11'h0}) begin bad++; $display("FAIL illegal_unmapped ill=%0b op=%h want 1 0", o_illegal, o_opcode); end
    i_inst = 32'h00500093;
    step();
    total++; if (o_illegal !== 1'b0) begin bad++; $display("FAIL illegal_clear got=%0b want=0", o_illegal); end
  endtask

  task automatic test_async_reset();
    i_ce = 1'b1; i_inst = 32'h00500093; i_pc = 32'h200;
    step();
    #2 i_rst = 1'b1;
    #1;
    total++; if (o_ce !== 1'b0) begin bad++; $display("FAIL async_ce got=%0b want=0", o_ce); end
    total++; if ({o_pc, o_rd_addr, o_imm, o_opcode, o_alu, o_illegal} !== 95'h0) begin bad++; $display("FAIL async_payload pc=%h rd=%0d imm=%h op=%h alu=%h want 0", o_pc, o_rd_addr, o_imm, o_opcode, o_alu); end
    i_rst = 1'b0;
    i_stall = 1'b1;
    step(); step();
    i_rst = 1'b1; i_stall = 1'b0;
    #1;
    total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL reset_mid_stall got=%0b want=0", o_stall); end
    i_rst = 1'b0; i_inst = 32'h402081B3; i_pc = 32'h204;
    step();
    total++; if ({o_ce, o_rd_addr, o_pc} !== {1'b1, 5'd3, 32'h204}) begin bad++; $display("FAIL post_reset_load ce=%0b rd=%0d pc=%h want 1 3 204", o_ce, o_rd_addr, o_pc); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_stall();
    test_flush();
    test_illegal();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1);
  end

endmodule

// File: doc/rv32_decode_stage.md
RV32_DECODE_STAGE -- requirements
Module: rv32_decode_stage

Interface
REQ-001 Parameter ILLEGAL_CHECK, default 1, meaning: 1 = flag malformed/unsupported encodings, 0 = never flag.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset; asynchronous, active-high.
REQ-004 i_inst  input  32  instruction word from fetch stage.
REQ-005 i_pc  input  32  PC of i_inst.
REQ-006 i_ce  input  1  fetch-stage valid/clock-enable for this stage.
REQ-007 i_stall  input  1  stall request from any downstream stage.
REQ-008 i_flush  input  1  flush request (branch/trap taken downstream).
REQ-009 o_stall  output  1  stall to fetch stage.
REQ-010 o_ce  output  1  valid/clock-enable to execute stage.
REQ-011 o_pc  output  32  PC of decoded instruction.
REQ-012 o_rs1_addr, o_rs2_addr, o_rd_addr  output  5 each  register indices (inst[19:15], [24:20], [11:7]).
REQ-013 o_funct3  output  3  inst[14:12].
REQ-014 o_imm  output  32  sign-extended immediate.
REQ-015 o_opcode  output  11  one-hot class: {RTYPE, ITYPE, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, FENCE}, bit 10 = RTYPE.
REQ-016 o_alu  output  14  one-hot ALU op: {ADD, SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA, EQ, NEQ, GE, GEU}, bit 13 = ADD.
REQ-017 o_illegal  output  1  registered illegal-instruction flag travelling with o_ce.

Function
REQ-018 stall_bit = i_stall OR stall_q; o_stall SHALL equal stall_bit combinationally; stall_q registers i_stall each cycle.
REQ-019 Payload registers (o_pc, addrs, funct3, imm, opcode, alu, illegal) SHALL load only when i_ce=1 and stall_bit=0; otherwise hold.
REQ-020 o_ce update priority: i_flush=1 and stall_bit=0 -> 0; else stall_bit=0 -> i_ce; else stall_bit=1 and i_stall=0 -> 0 (bubble); else hold.
REQ-021 Latency: one cycle from i_inst/i_ce sampled to o_* valid.
REQ-022 Immediate: I = {{20{i[31]}},i[31:20]}; S = {{20{i[31]}},i[31:25],i[11:7]}; B = {{19{i[31]}},i[31],i[7],i[30:25],i[11:8],0}; U = {i[31:12],12'b0}; J = {{11{i[31]}},i[31],i[19:12],i[20],i[30:21],0}; RTYPE/FENCE/SYSTEM -> 0.
REQ-023 Opcode map (inst[6:2]): 01100 RTYPE, 00100 ITYPE, 00000 LOAD, 01000 STORE, 11000 BRANCH, 11011 JAL, 11001 JALR, 01101 LUI, 00101 AUIPC, 11100 SYSTEM, 00011 FENCE.
REQ-024 ALU: RTYPE/ITYPE by funct3 (000 ADD, or SUB when RTYPE and inst[30]=1; 010 SLT; 011 SLTU; 100 XOR; 110 OR; 111 AND; 001 SLL; 101 SRL, or SRA when inst[30]=1); BRANCH funct3 000 EQ, 001 NEQ, 100 SLT, 101 GE, 110 SLTU, 111 GEU; all other classes ADD.
REQ-025 With ILLEGAL_CHECK=1, o_illegal=1 when inst[1:0]!=2'b11, opcode unmapped, or BRANCH funct3 in {010,011}; then o_opcode=0, o_alu=0; o_ce still follows REQ-020.
REQ-026 Flush while stalled SHALL not clear o_ce until stall_bit=0 (REQ-020 priority).
REQ-027 Exactly one o_opcode bit and one o_alu bit high whenever o_ce=1 and o_illegal=0.

Reset
REQ-028 i_rst=1 SHALL immediately clear o_ce, stall_q, o_illegal and every payload output to 0, independent of i_clk.
REQ-029 Reset asserted mid-stall SHALL drop o_stall to i_stall (stall_q=0); first post-reset edge with i_ce=1 loads normally.

Verification
REQ-030 i_inst=0x00500093 (ADDI x1,x0,5), i_ce=1 -> next cycle o_ce=1, o_rd_addr=1, o_rs1_addr=0, o_imm=5, ITYPE, ADD.
REQ-031 i_inst=0x402081B3 (SUB x3,x1,x2) -> RTYPE, SUB, rd=3, rs1=1, rs2=2, o_imm=0.
REQ-032 i_inst=0xFE000EE3 (BEQ x0,x0,-4) -> BRANCH, EQ, o_imm=0xFFFFFFFC; i_inst=0x123452B7 -> LUI, rd=5, o_imm=0x12345000.
REQ-033 i_stall=1 for 3 cycles while new i_inst applied -> outputs hold original; on i_stall 1->0 o_ce=0 one cycle (bubble), then resumes.
REQ-034 i_flush=1, i_stall=0, i_ce=1 -> next cycle o_ce=0; i_inst=0x00000000 -> o_illegal=1, o_opcode=0, o_alu=0.
REQ-035 i_rst pulsed between clock edges with o_ce=1 -> o_ce and all payload outputs 0 before next edge.
